// File: rtl/led_strip_serializer.sv
// WS2812-style strip serializer: accepts one RGB frame, scales it by brightness,
// reorders each pixel to GRB and drives the single-wire NRZ bitstream plus latch gap.
module led_strip_serializer #(
   parameter int NUM_LEDS     = 10,
   parameter int T0H          = 8,
   parameter int T1H          = 16,
   parameter int T_BIT        = 25,
   parameter int RESET_CYCLES = 1000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_LEDS*24-1:0] frame_in,
   input  logic [2:0]            brightness,
   input  logic                  frame_valid,
   output logic                  frame_ready,
   output logic                  led_dout,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int NB = NUM_LEDS * 24;
   localparam int CW = $clog2(T_BIT + 1);
   localparam int LW = $clog2(NUM_LEDS + 1);
   localparam int RW = $clog2(RESET_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SEND  = 2'd2,
      LATCH = 2'd3
   } state_t;

   state_t          state_r, state_s;
   logic [NB-1:0]   frame_r, shift_r, shift_s, scaled_s;
   logic [2:0]      bright_r;
   logic [CW-1:0]   cyc_cnt_r, cyc_cnt_s, high_s;
   logic [4:0]      bit_cnt_r, bit_cnt_s;
   logic [LW-1:0]   led_cnt_r, led_cnt_s;
   logic [RW-1:0]   latch_cnt_r, latch_cnt_s;
   logic            ready_s, busy_s, done_s, dout_s, accept_s;

   // c*(b+1) computed as c*b + c so the product stays inside 11 bits
   function automatic logic [7:0] scale(input logic [7:0] c, input logic [2:0] b);
      logic [10:0] p;
      p = ({3'd0, c} * {8'd0, b}) + {3'd0, c};
      return p[10:3];
   endfunction

   // Scaled frame in transmit order: pixel 0 at the top, each pixel as G,R,B
   always_comb begin
      scaled_s = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         scaled_s[NB-1-24*i -: 24] = {scale(frame_r[24*i+8 +: 8], bright_r),
                                      scale(frame_r[24*i+16 +: 8], bright_r),
                                      scale(frame_r[24*i +: 8], bright_r)};
      end
   end

   // Next-state, counter and output decode
   always_comb begin
      state_s     = state_r;
      shift_s     = shift_r;
      cyc_cnt_s   = cyc_cnt_r;
      bit_cnt_s   = bit_cnt_r;
      led_cnt_s   = led_cnt_r;
      latch_cnt_s = latch_cnt_r;
      ready_s     = 1'b0;
      busy_s      = 1'b1;
      done_s      = 1'b0;
      dout_s      = 1'b0;
      accept_s    = 1'b0;
      high_s      = shift_r[NB-1] ? CW'(T1H) : CW'(T0H);
      case (state_r)
         IDLE: begin
            if (frame_valid && frame_ready) begin
               accept_s = 1'b1;
               state_s  = LOAD;
            end else begin
               ready_s = 1'b1;
               busy_s  = 1'b0;
            end
         end
         LOAD: begin
            shift_s   = scaled_s;
            cyc_cnt_s = '0;
            bit_cnt_s = '0;
            led_cnt_s = '0;
            dout_s    = 1'b1;
            state_s   = SEND;
         end
         SEND: begin
            if (cyc_cnt_r == CW'(T_BIT - 1)) begin
               cyc_cnt_s = '0;
               shift_s   = {shift_r[NB-2:0], 1'b0};
               dout_s    = 1'b1;
               if (bit_cnt_r == 5'd23) begin
                  bit_cnt_s = '0;
                  if (led_cnt_r == LW'(NUM_LEDS - 1)) begin
                     led_cnt_s   = '0;
                     latch_cnt_s = '0;
                     dout_s      = 1'b0;
                     state_s     = LATCH;
                  end else begin
                     led_cnt_s = led_cnt_r + LW'(1);
                  end
               end else begin
                  bit_cnt_s = bit_cnt_r + 5'd1;
               end
            end else begin
               cyc_cnt_s = cyc_cnt_r + CW'(1);
               dout_s    = (cyc_cnt_r + CW'(1)) < high_s;
            end
         end
         LATCH: begin
            if (latch_cnt_r == RW'(RESET_CYCLES - 1)) begin
               latch_cnt_s = '0;
               state_s     = IDLE;
               ready_s     = 1'b1;
               busy_s      = 1'b0;
               done_s      = 1'b1;
            end else begin
               latch_cnt_s = latch_cnt_r + RW'(1);
            end
         end
         default: begin
            state_s = IDLE;
            ready_s = 1'b1;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State, counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         shift_r     <= '0;
         cyc_cnt_r   <= '0;
         bit_cnt_r   <= '0;
         led_cnt_r   <= '0;
         latch_cnt_r <= '0;
         frame_ready <= 1'b1;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         led_dout    <= 1'b0;
      end else begin
         state_r     <= state_s;
         shift_r     <= shift_s;
         cyc_cnt_r   <= cyc_cnt_s;
         bit_cnt_r   <= bit_cnt_s;
         led_cnt_r   <= led_cnt_s;
         latch_cnt_r <= latch_cnt_s;
         frame_ready <= ready_s;
         busy        <= busy_s;
         frame_done  <= done_s;
         led_dout    <= dout_s;
      end
   end

   // Frame and brightness capture on accept
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_r  <= '0;
         bright_r <= 3'd0;
      end else if (accept_s) begin
         frame_r  <= frame_in;
         bright_r <= brightness;
      end else begin
         frame_r  <= frame_r;
         bright_r <= bright_r;
      end
   end

endmodule

// File: tb/tb_led_strip_serializer.sv
// Self-checking bench for led_strip_serializer: random frames compared against a
// bit-level reference model built directly from the scaling and GRB ordering rules.
module tb_led_strip_serializer;

   localparam int N        = 10;
   localparam int T0H      = 2;
   localparam int T1H      = 4;
   localparam int TB       = 6;
   localparam int RC       = 10;
   localparam int NB       = N * 24;
   localparam int DONE_OFF = 1 + NB * TB + RC;

   logic          clk;
   logic          rst;
   logic [NB-1:0] frame_in;
   logic [2:0]    brightness;
   logic          frame_valid;
   logic          frame_ready;
   logic          led_dout;
   logic          busy;
   logic          frame_done;

   int checks;
   int failures;

   logic          exp_bits [NB];
   logic [TB-1:0] cap_pat  [NB];
   logic          cap_dout0, cap_gap_hi, cap_ready_bp, cap_done_next;
   logic          cap_ready_done, cap_busy_done;
   int            cap_done_c;

   led_strip_serializer #(
      .NUM_LEDS(N), .T0H(T0H), .T1H(T1H), .T_BIT(TB), .RESET_CYCLES(RC)
   ) dut (
      .clk(clk), .rst(rst), .frame_in(frame_in), .brightness(brightness),
      .frame_valid(frame_valid), .frame_ready(frame_ready), .led_dout(led_dout),
      .busy(busy), .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [TB-1:0] exp_pat(input logic b);
      logic [TB-1:0] p;
      p = '0;
      for (int j = 0; j < TB; j++) p[j] = (j < (b ? T1H : T0H));
      return p;
   endfunction

   function automatic logic [NB-1:0] rand_frame();
      logic [NB-1:0] f;
      for (int i = 0; i < N; i++) f[24*i +: 24] = 24'($urandom);
      return f;
   endfunction

   // Reference: scaled channel = c*(b+1)/8, sent pixel 0 first, G,R,B, MSB first
   task automatic model_frame(input logic [NB-1:0] f, input int b);
      int idx;
      logic [7:0] ch [3];
      idx = 0;
      for (int i = 0; i < N; i++) begin
         ch[0] = 8'((int'(f[24*i+8 +: 8]) * (b + 1)) / 8);
         ch[1] = 8'((int'(f[24*i+16 +: 8]) * (b + 1)) / 8);
         ch[2] = 8'((int'(f[24*i +: 8]) * (b + 1)) / 8);
         for (int c = 0; c < 3; c++) begin
            for (int bt = 7; bt >= 0; bt--) begin
               exp_bits[idx] = ch[c][bt];
               idx++;
            end
         end
      end
   endtask

   // Offer a frame and return #1 after the accepting edge
   task automatic offer(input logic [NB-1:0] f, input logic [2:0] b, input logic hold);
      int n;
      frame_in    = f;
      brightness  = b;
      frame_valid = 1'b1;
      n = 0;
      while (!frame_ready && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 5000) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout: frame_ready=%0b required 1", frame_ready);
      end
      @(posedge clk); #1;
      if (!hold) frame_valid = 1'b0;
   endtask

   // Record the waveform from the LOAD cycle through the cycle after frame_done
   task automatic capture(input int bp_cycle, input logic [NB-1:0] bp_frame);
      int c;
      for (int k = 0; k < NB; k++) cap_pat[k] = '0;
      cap_dout0     = led_dout;
      cap_done_c    = -1;
      cap_gap_hi    = 1'b0;
      cap_ready_bp  = 1'b1;
      cap_done_next = 1'b1;
      c = 0;
      while (c <= DONE_OFF + 20) begin
         @(posedge clk); #1;
         c++;
         if (c == bp_cycle) begin
            cap_ready_bp = frame_ready;
            frame_in     = bp_frame;
            brightness   = 3'($urandom);
            frame_valid  = 1'b1;
         end else if (c == bp_cycle + 1) begin
            frame_valid = 1'b0;
         end
         if (c <= NB * TB) cap_pat[(c-1)/TB][(c-1)%TB] = led_dout;
         else if (c <= NB * TB + RC && led_dout) cap_gap_hi = 1'b1;
         if (cap_done_c >= 0) begin
            cap_done_next = frame_done;
            break;
         end
         if (frame_done) begin
            cap_done_c     = c;
            cap_ready_done = frame_ready;
            cap_busy_done  = busy;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      frame_valid = 1'b0;
      frame_in = '0;
      brightness = 3'd0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (led_dout !== 1'b0) begin failures++; $display("FAIL reset_dout: got %0b want 0", led_dout); end
      checks++; if (frame_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0b want 1", frame_ready); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", busy); end
      checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b want 0", frame_done); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_full_frame();
      logic [NB-1:0] f;
      for (int i = 0; i < N; i++) f[24*i +: 24] = 24'hFF0000;
      model_frame(f, 7);
      offer(f, 3'd7, 1'b0);
      checks++; if (busy !== 1'b1 || frame_ready !== 1'b0) begin failures++; $display("FAIL accept_flags: busy=%0b ready=%0b want 1/0", busy, frame_ready); end
      frame_in = rand_frame();
      capture(-1, '0);
      checks++; if (cap_dout0 !== 1'b0) begin failures++; $display("FAIL first_rise_load: dout=%0b want 0", cap_dout0); end
      for (int k = 0; k < NB; k++) begin
         checks++;
         if (cap_pat[k] !== exp_pat(exp_bits[k])) begin
            failures++; $display("FAIL full_bit%0d: got %b want %b", k, cap_pat[k], exp_pat(exp_bits[k]));
         end
      end
      checks++; if (cap_gap_hi !== 1'b0) begin failures++; $display("FAIL full_latch_low: high seen %0b want 0", cap_gap_hi); end
      checks++; if (cap_done_c != DONE_OFF) begin failures++; $display("FAIL full_done_time: got %0d want %0d", cap_done_c, DONE_OFF); end
      checks++; if (cap_ready_done !== 1'b1 || cap_busy_done !== 1'b0) begin failures++; $display("FAIL full_done_flags: ready=%0b busy=%0b want 1/0", cap_ready_done, cap_busy_done); end
      checks++; if (cap_done_next !== 1'b0) begin failures++; $display("FAIL full_done_width: next=%0b want 0", cap_done_next); end
   endtask

   task automatic test_scaling();
      logic [NB-1:0] f;
      logic [23:0]   got, want;
      int            b;
      for (int t = 0; t < 3; t++) begin
         case (t)
            0: begin b = 3; want = 24'h407F00; end
            1: begin b = 0; want = 24'h101F00; end
            default: begin b = 7; want = 24'h80FF01; end
         endcase
         f = rand_frame();
         f[23:0] = 24'hFF8001;
         model_frame(f, b);
         offer(f, 3'(b), 1'b0);
         capture(-1, '0);
         for (int k = 0; k < 24; k++) got[23-k] = (cap_pat[k] === exp_pat(1'b1));
         checks++; if (got !== want) begin failures++; $display("FAIL scale_b%0d: GRB got %h want %h", b, got, want); end
         for (int k = 24; k < NB; k++) begin
            checks++;
            if (cap_pat[k] !== exp_pat(exp_bits[k])) begin
               failures++; $display("FAIL scale_b%0d_bit%0d: got %b want %b", b, k, cap_pat[k], exp_pat(exp_bits[k]));
            end
         end
         checks++; if (cap_done_c != DONE_OFF) begin failures++; $display("FAIL scale_done_time: got %0d want %0d", cap_done_c, DONE_OFF); end
      end
   endtask

   task automatic test_backpressure();
      logic [NB-1:0] f;
      int b;
      f = rand_frame();
      b = int'($urandom_range(0, 7));
      model_frame(f, b);
      offer(f, 3'(b), 1'b0);
      capture(200, rand_frame());
      checks++; if (cap_ready_bp !== 1'b0) begin failures++; $display("FAIL bp_ready: got %0b want 0", cap_ready_bp); end
      for (int k = 0; k < NB; k++) begin
         checks++;
         if (cap_pat[k] !== exp_pat(exp_bits[k])) begin
            failures++; $display("FAIL bp_bit%0d: got %b want %b", k, cap_pat[k], exp_pat(exp_bits[k]));
         end
      end
      checks++; if (cap_done_c != DONE_OFF) begin failures++; $display("FAIL bp_done_time: got %0d want %0d", cap_done_c, DONE_OFF); end
      checks++; if (busy !== 1'b0 || frame_ready !== 1'b1) begin failures++; $display("FAIL bp_not_queued: busy=%0b ready=%0b want 0/1", busy, frame_ready); end
   endtask

   task automatic test_reset_mid_frame();
      logic [NB-1:0] f;
      int b;
      logic seen;
      offer(rand_frame(), 3'($urandom), 1'b0);
      repeat (1 + 37 * TB) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (led_dout !== 1'b0 || frame_ready !== 1'b1) begin failures++; $display("FAIL mid_reset: dout=%0b ready=%0b want 0/1", led_dout, frame_ready); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy: got %0b want 0", busy); end
      rst = 1'b0;
      seen = 1'b0;
      repeat (DONE_OFF + 10) begin
         @(posedge clk); #1;
         if (frame_done || led_dout) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_no_done: activity=%0b want 0", seen); end
      f = rand_frame();
      b = int'($urandom_range(0, 7));
      model_frame(f, b);
      offer(f, 3'(b), 1'b0);
      capture(-1, '0);
      for (int k = 0; k < NB; k++) begin
         checks++;
         if (cap_pat[k] !== exp_pat(exp_bits[k])) begin
            failures++; $display("FAIL mid_new_bit%0d: got %b want %b", k, cap_pat[k], exp_pat(exp_bits[k]));
         end
      end
      checks++; if (cap_done_c != DONE_OFF) begin failures++; $display("FAIL mid_new_done: got %0d want %0d", cap_done_c, DONE_OFF); end
   endtask

   task automatic test_back_to_back();
      logic [NB-1:0] fa, fb;
      int ba, bb;
      logic gap_a;
      fa = rand_frame();
      fb = rand_frame();
      ba = int'($urandom_range(0, 7));
      bb = int'($urandom_range(0, 7));
      model_frame(fa, ba);
      offer(fa, 3'(ba), 1'b1);
      frame_in   = fb;
      brightness = 3'(bb);
      capture(-1, '0);
      frame_valid = 1'b0;
      gap_a = cap_gap_hi;
      for (int k = 0; k < NB; k++) begin
         checks++;
         if (cap_pat[k] !== exp_pat(exp_bits[k])) begin
            failures++; $display("FAIL b2b_a_bit%0d: got %b want %b", k, cap_pat[k], exp_pat(exp_bits[k]));
         end
      end
      checks++; if (cap_done_c != DONE_OFF) begin failures++; $display("FAIL b2b_a_done: got %0d want %0d", cap_done_c, DONE_OFF); end
      checks++; if (cap_ready_done !== 1'b1) begin failures++; $display("FAIL b2b_ready_in_done: got %0b want 1", cap_ready_done); end
      checks++; if (busy !== 1'b1 || frame_ready !== 1'b0) begin failures++; $display("FAIL b2b_b_accept: busy=%0b ready=%0b want 1/0", busy, frame_ready); end
      model_frame(fb, bb);
      capture(-1, '0);
      checks++; if (gap_a !== 1'b0 || cap_dout0 !== 1'b0) begin failures++; $display("FAIL b2b_gap: latch_high=%0b load_dout=%0b want 0/0", gap_a, cap_dout0); end
      for (int k = 0; k < NB; k++) begin
         checks++;
         if (cap_pat[k] !== exp_pat(exp_bits[k])) begin
            failures++; $display("FAIL b2b_b_bit%0d: got %b want %b", k, cap_pat[k], exp_pat(exp_bits[k]));
         end
      end
      checks++; if (cap_done_c != DONE_OFF) begin failures++; $display("FAIL b2b_b_done: got %0d want %0d", cap_done_c, DONE_OFF); end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_full_frame();
      test_scaling();
      test_backpressure();
      test_reset_mid_frame();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
